cipu_sink: RTL and testbench
============================

CIPU_SINK -- requirements
Module: cipu_sink

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 valid_fifo, valid_lifo, valid_fifo2  input  1 each  per-channel data-valid strobes from the CIPU stage.
REQ-004 people_thing_out  input  8  FIFO channel data, sampled when valid_fifo=1.
REQ-005 thing_out  input  8  shared data for the LIFO channel (valid_lifo) and the FIFO2 channel (valid_fifo2).
REQ-006 done_thing, done_fifo, done_lifo, done_fifo2  input  1 each  completion pulses from the CIPU stage.
REQ-007 clr  input  1  synchronous clear of all channels; rst has priority.
REQ-008 rd_sel  input  2  read channel select: 0=FIFO, 1=LIFO, 2=FIFO2, 3=reserved.
REQ-009 rd_addr  input  4  read index into the selected buffer.
REQ-010 rd_data  output  8  registered read data.
REQ-011 fifo_cnt, lifo_cnt, fifo2_cnt  output  5 each  entries captured per channel, 0..16.
REQ-012 group_cnt  output  4  done_thing pulses counted; wraps 15->0.
REQ-013 all_done  output  1  registered; 1 while all three channels are in DONE.
REQ-014 err  output  1  sticky protocol-error flag.

Function
REQ-015 Each channel SHALL run its own FSM: IDLE -> COLLECT on the first valid; COLLECT -> DONE on its done pulse; DONE -> IDLE only on clr.
REQ-016 Done pulse mapping SHALL be: FIFO=done_fifo, LIFO=done_lifo, FIFO2=done_fifo2; done_thing SHALL NOT change any FSM state.
REQ-017 In IDLE or COLLECT, a valid=1 cycle SHALL write the data to buffer[cnt] and increment cnt in the same edge; capture latency is 1 cycle.
REQ-018 Valid and done in the same cycle SHALL capture the data, then enter DONE.
REQ-019 A done pulse in IDLE SHALL enter DONE with cnt=0.
REQ-020 Valid at cnt=16 SHALL be dropped, cnt SHALL hold at 16, and err SHALL be set.
REQ-021 Valid while in DONE SHALL be ignored and SHALL set err.
REQ-022 valid_lifo and valid_fifo2 both 1 in one cycle SHALL set err, and both channels SHALL still capture thing_out.
REQ-023 group_cnt SHALL increment on every clk edge where done_thing=1, in any LIFO state.
REQ-024 rd_data SHALL equal buffer[rd_addr] of the selected channel one cycle after rd_sel/rd_addr are applied.
REQ-025 rd_data SHALL be 8'h00 when rd_addr >= the selected cnt or rd_sel=3.
REQ-026 A read and a write to the same entry in one cycle SHALL return the old contents.
REQ-027 clr SHALL return every FSM to IDLE and zero all cnt, group_cnt, err, all_done and rd_data; buffer contents need not be cleared.
REQ-028 clr and valid in the same cycle: clr SHALL win and the data SHALL be dropped.

Reset
REQ-029 rst SHALL asynchronously force: FSMs=IDLE, all cnt=0, group_cnt=0, rd_data=8'h00, all_done=0, err=0.
REQ-030 rst asserted mid-collection SHALL discard partial captures; the first valid after release starts at index 0.

Structure
REQ-031 A shared package SHALL hold: the FSM state encoding (IDLE/COLLECT/DONE), DEPTH=16, the rd_sel codes, and the character constants 8'h24 '$', 8'h3B ';', 8'h30 '0'.
REQ-032 One sub-module, cipu_sink_chan, SHALL hold one FSM, its 16x8 buffer and its counter; it SHALL be instantiated three times.
REQ-033 The top level SHALL hold the read mux, group_cnt, all_done and err.

Verification
REQ-034 FIFO capture: valid_fifo pulses with "A","B","C", then done_fifo -> fifo_cnt=3; reads of index 0..2 return 41,42,43; index 3 returns 00.
REQ-035 LIFO groups: push "X","Y" with done_thing, then "0" (8'h30) with done_thing, then done_lifo -> lifo_cnt=3, group_cnt=2, LIFO channel in DONE.
REQ-036 Overflow: 17 valid_fifo2 pulses -> fifo2_cnt=16, err=1, last entry is the 16th datum.
REQ-037 Same-cycle events: valid_fifo and done_fifo on the same edge with 8'h5A -> fifo_cnt=1, entry 0 = 5A, FSM in DONE; a later valid_fifo sets err.
REQ-038 Completion: done on all three channels in any order -> all_done=1 one cycle after the last done; clr -> all_done=0 and all cnt=0.
REQ-039 Reset mid-run: rst asserted after 5 FIFO captures, then "Q" captured after release -> fifo_cnt=1, entry 0 = 51.

Source files
------------

// File: rtl/cipu_sink_pkg.sv
// Shared types and constants for the CIPU sink: channel FSM encoding, buffer
// geometry, read-select codes and the character constants used by the CIPU stream.
package cipu_sink_pkg;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } chan_state_t;

  typedef enum logic [1:0] {
    SEL_FIFO  = 2'd0,
    SEL_LIFO  = 2'd1,
    SEL_FIFO2 = 2'd2,
    SEL_RSVD  = 2'd3
  } rd_sel_t;

  localparam logic [DATA_W-1:0] CH_DOLLAR = 8'h24;
  localparam logic [DATA_W-1:0] CH_SEMI   = 8'h3B;
  localparam logic [DATA_W-1:0] CH_ZERO   = 8'h30;

  // An entry is readable only once it has been captured.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr,
                                    input logic [CNT_W-1:0]  cnt);
    return {1'b0, addr} < cnt;
  endfunction

endpackage

// File: rtl/cipu_sink_if.sv
// Bus between the CIPU stage (master) and the sink (slave): capture strobes,
// completion pulses, clear, read port and status.
interface cipu_sink_if;
  import cipu_sink_pkg::*;

  logic              valid_fifo;
  logic              valid_lifo;
  logic              valid_fifo2;
  logic [DATA_W-1:0] people_thing_out;
  logic [DATA_W-1:0] thing_out;
  logic              done_thing;
  logic              done_fifo;
  logic              done_lifo;
  logic              done_fifo2;
  logic              clr;
  logic [1:0]        rd_sel;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [CNT_W-1:0]  lifo_cnt;
  logic [CNT_W-1:0]  fifo2_cnt;
  logic [3:0]        group_cnt;
  logic              all_done;
  logic              err;

  modport master (
    output valid_fifo, valid_lifo, valid_fifo2, people_thing_out, thing_out,
           done_thing, done_fifo, done_lifo, done_fifo2, clr, rd_sel, rd_addr,
    input  rd_data, fifo_cnt, lifo_cnt, fifo2_cnt, group_cnt, all_done, err
  );

  modport slave (
    input  valid_fifo, valid_lifo, valid_fifo2, people_thing_out, thing_out,
           done_thing, done_fifo, done_lifo, done_fifo2, clr, rd_sel, rd_addr,
    output rd_data, fifo_cnt, lifo_cnt, fifo2_cnt, group_cnt, all_done, err
  );

endinterface

// File: rtl/cipu_sink_chan.sv
// One capture channel: IDLE/COLLECT/DONE FSM, 16x8 buffer and fill counter.
// Reports protocol errors (overflow, valid after done) as single-cycle pulses.
module cipu_sink_chan
  import cipu_sink_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_done,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_word,
  output logic [CNT_W-1:0]  o_cnt,
  output logic              o_done_nxt,
  output logic              o_err
);

  chan_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_full, w_wr_en, w_err;

  assign w_full = (r_cnt == CNT_W'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    if (i_clr) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (i_done) w_state_nxt = ST_DONE;
                    else if (i_valid) w_state_nxt = ST_COLLECT;
        ST_COLLECT: if (i_done) w_state_nxt = ST_DONE;
        ST_DONE:    w_state_nxt = ST_DONE;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_wr_en = 1'b0;
    w_err   = 1'b0;
    if (!i_clr && i_valid) begin
      case (r_state)
        ST_IDLE, ST_COLLECT: if (w_full) w_err = 1'b1;
                             else        w_wr_en = 1'b1;
        default:             w_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_cnt <= '0;
    else if (i_clr)   r_cnt <= '0;
    else if (w_wr_en) r_cnt <= r_cnt + 1'b1;
  end

  // NOTE: the buffer has no reset; entries at or beyond the count are never visible.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_cnt[ADDR_W-1:0]] <= i_data;
  end

  assign o_rd_word  = r_mem[i_rd_addr];
  assign o_cnt      = r_cnt;
  assign o_done_nxt = (w_state_nxt == ST_DONE);
  assign o_err      = w_err;

endmodule

// File: rtl/cipu_sink.sv
// CIPU sink top: three capture channels, registered read mux, done-group
// counter, all-done flag and sticky protocol-error flag.
module cipu_sink
  import cipu_sink_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  cipu_sink_if.slave  bus
);

  logic [DATA_W-1:0] w_word [3];
  logic [CNT_W-1:0]  w_cnt  [3];
  logic [2:0]        w_done_nxt, w_chan_err;
  logic [DATA_W-1:0] w_rd_nxt;
  logic              w_collide;
  logic [DATA_W-1:0] r_rd_data;
  logic [3:0]        r_group_cnt;
  logic              r_all_done, r_err;

  cipu_sink_chan u_fifo (
    .clk(clk), .rst(rst), .i_clr(bus.clr), .i_valid(bus.valid_fifo),
    .i_data(bus.people_thing_out), .i_done(bus.done_fifo), .i_rd_addr(bus.rd_addr),
    .o_rd_word(w_word[0]), .o_cnt(w_cnt[0]), .o_done_nxt(w_done_nxt[0]), .o_err(w_chan_err[0])
  );

  cipu_sink_chan u_lifo (
    .clk(clk), .rst(rst), .i_clr(bus.clr), .i_valid(bus.valid_lifo),
    .i_data(bus.thing_out), .i_done(bus.done_lifo), .i_rd_addr(bus.rd_addr),
    .o_rd_word(w_word[1]), .o_cnt(w_cnt[1]), .o_done_nxt(w_done_nxt[1]), .o_err(w_chan_err[1])
  );

  cipu_sink_chan u_fifo2 (
    .clk(clk), .rst(rst), .i_clr(bus.clr), .i_valid(bus.valid_fifo2),
    .i_data(bus.thing_out), .i_done(bus.done_fifo2), .i_rd_addr(bus.rd_addr),
    .o_rd_word(w_word[2]), .o_cnt(w_cnt[2]), .o_done_nxt(w_done_nxt[2]), .o_err(w_chan_err[2])
  );

  // Buffer words are sampled before the edge, so a same-cycle write returns old data.
  always_comb begin
    w_rd_nxt = '0;
    case (rd_sel_t'(bus.rd_sel))
      SEL_FIFO:  if (in_range(bus.rd_addr, w_cnt[0])) w_rd_nxt = w_word[0];
      SEL_LIFO:  if (in_range(bus.rd_addr, w_cnt[1])) w_rd_nxt = w_word[1];
      SEL_FIFO2: if (in_range(bus.rd_addr, w_cnt[2])) w_rd_nxt = w_word[2];
      default:   w_rd_nxt = '0;
    endcase
  end

  // LIFO and FIFO2 share thing_out, so both strobing at once is a protocol error.
  assign w_collide = bus.valid_lifo & bus.valid_fifo2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data   <= '0;
      r_group_cnt <= '0;
      r_all_done  <= 1'b0;
      r_err       <= 1'b0;
    end else if (bus.clr) begin
      r_rd_data   <= '0;
      r_group_cnt <= '0;
      r_all_done  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_rd_data  <= w_rd_nxt;
      r_all_done <= &w_done_nxt;
      if (bus.done_thing)            r_group_cnt <= r_group_cnt + 1'b1;
      if (|w_chan_err || w_collide)  r_err <= 1'b1;
    end
  end

  assign bus.rd_data   = r_rd_data;
  assign bus.fifo_cnt  = w_cnt[0];
  assign bus.lifo_cnt  = w_cnt[1];
  assign bus.fifo2_cnt = w_cnt[2];
  assign bus.group_cnt = r_group_cnt;
  assign bus.all_done  = r_all_done;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_cipu_sink.sv
// Self-checking bench for cipu_sink: directed scenarios plus randomized traffic,
// all compared against a queue-free array model of the capture/read rules.
module tb_cipu_sink;
  import cipu_sink_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cipu_sink_if bus();
  cipu_sink dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: per-channel captured bytes, fill count and finished flag.
  logic [7:0] m_buf [3][16];
  logic [4:0] m_cnt [3];
  bit         m_fin [3];
  logic [3:0] m_grp;
  logic [7:0] m_rd;
  bit         m_all, m_err;

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin m_cnt[c] = 0; m_fin[c] = 0; end
    m_grp = 0; m_rd = 0; m_all = 0; m_err = 0;
  endtask

  task automatic model_eval();
    bit         v [3];
    bit         dn[3];
    logic [7:0] d [3];
    v  = '{bus.valid_fifo, bus.valid_lifo, bus.valid_fifo2};
    dn = '{bus.done_fifo, bus.done_lifo, bus.done_fifo2};
    d  = '{bus.people_thing_out, bus.thing_out, bus.thing_out};
    m_rd = 8'h00;
    if (!bus.clr && bus.rd_sel != 2'd3 && {1'b0, bus.rd_addr} < m_cnt[bus.rd_sel])
      m_rd = m_buf[bus.rd_sel][bus.rd_addr];
    if (bus.clr) begin
      model_reset();
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (v[c]) begin
          if (m_fin[c] || m_cnt[c] == 5'd16) m_err = 1;
          else begin m_buf[c][m_cnt[c][3:0]] = d[c]; m_cnt[c] = m_cnt[c] + 1; end
        end
        if (dn[c]) m_fin[c] = 1;
      end
      if (v[1] && v[2]) m_err = 1;
      if (bus.done_thing) m_grp = m_grp + 1;
      m_all = m_fin[0] && m_fin[1] && m_fin[2];
    end
  endtask

  function automatic logic [28:0] exp_vec();
    return {m_rd, m_cnt[0], m_cnt[1], m_cnt[2], m_grp, m_all, m_err};
  endfunction

  function automatic logic [28:0] dut_vec();
    return {bus.rd_data, bus.fifo_cnt, bus.lifo_cnt, bus.fifo2_cnt,
            bus.group_cnt, bus.all_done, bus.err};
  endfunction

  task automatic idle_inputs();
    bus.valid_fifo = 0; bus.valid_lifo = 0; bus.valid_fifo2 = 0;
    bus.done_thing = 0; bus.done_fifo = 0; bus.done_lifo = 0; bus.done_fifo2 = 0;
    bus.clr = 0;
  endtask

  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    idle_inputs(); bus.clr = 1; step(); bus.clr = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.people_thing_out = 0; bus.thing_out = 0; bus.rd_sel = 0; bus.rd_addr = 0;
    rst = 1; model_reset();
    #3;
    n_checks++;
    if (dut_vec() !== 29'd0) $display("FAIL reset_state: got %h expected %h", dut_vec(), 29'd0);
    else n_pass++;
    @(negedge clk); rst = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL reset_idle: got %h expected %h", dut_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_fifo_capture();
    logic [7:0] want [4];
    logic [7:0] abc [3];
    want = '{8'h41, 8'h42, 8'h43, 8'h00};
    abc  = '{8'h41, 8'h42, 8'h43};
    do_clr();
    for (int i = 0; i < 3; i++) begin
      bus.valid_fifo = 1; bus.people_thing_out = abc[i]; step();
    end
    bus.valid_fifo = 0; bus.done_fifo = 1; step(); bus.done_fifo = 0;
    n_checks++;
    if (bus.fifo_cnt !== 5'd3) $display("FAIL fifo_cnt: got %0d expected 3", bus.fifo_cnt);
    else n_pass++;
    bus.rd_sel = 2'd0;
    for (int i = 0; i < 4; i++) begin
      bus.rd_addr = 4'(i); step();
      n_checks++;
      if (bus.rd_data !== want[i]) $display("FAIL fifo_read[%0d]: got %h expected %h", i, bus.rd_data, want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_lifo_groups();
    do_clr();
    bus.valid_lifo = 1; bus.thing_out = 8'h58; step();
    bus.thing_out = 8'h59; bus.done_thing = 1; step();
    bus.thing_out = CH_ZERO; step();
    bus.valid_lifo = 0; bus.done_thing = 0; bus.done_lifo = 1; step();
    bus.done_lifo = 0;
    n_checks++;
    if ({bus.lifo_cnt, bus.group_cnt, bus.err} !== {5'd3, 4'd2, 1'b0})
      $display("FAIL lifo_groups: got cnt=%0d grp=%0d err=%0d expected cnt=3 grp=2 err=0",
               bus.lifo_cnt, bus.group_cnt, bus.err);
    else n_pass++;
    bus.rd_sel = 2'd1; bus.rd_addr = 4'd2; step();
    n_checks++;
    if (bus.rd_data !== CH_ZERO) $display("FAIL lifo_read2: got %h expected %h", bus.rd_data, CH_ZERO);
    else n_pass++;
    bus.valid_lifo = 1; bus.thing_out = 8'h5E; step(); bus.valid_lifo = 0;
    n_checks++;
    if ({bus.lifo_cnt, bus.err} !== {5'd3, 1'b1})
      $display("FAIL lifo_in_done: got cnt=%0d err=%0d expected cnt=3 err=1", bus.lifo_cnt, bus.err);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [7:0] d [17];
    do_clr();
    for (int i = 0; i < 17; i++) d[i] = 8'($urandom);
    d[0] = CH_DOLLAR;
    for (int i = 0; i < 17; i++) begin
      bus.valid_fifo2 = 1; bus.thing_out = d[i]; step();
      if (i == 15) begin
        n_checks++;
        if ({bus.fifo2_cnt, bus.err} !== {5'd16, 1'b0})
          $display("FAIL fifo2_full: got cnt=%0d err=%0d expected cnt=16 err=0", bus.fifo2_cnt, bus.err);
        else n_pass++;
      end
    end
    bus.valid_fifo2 = 0;
    n_checks++;
    if ({bus.fifo2_cnt, bus.err} !== {5'd16, 1'b1})
      $display("FAIL fifo2_overflow: got cnt=%0d err=%0d expected cnt=16 err=1", bus.fifo2_cnt, bus.err);
    else n_pass++;
    bus.rd_sel = 2'd2; bus.rd_addr = 4'd15; step();
    n_checks++;
    if (bus.rd_data !== d[15]) $display("FAIL fifo2_last: got %h expected %h", bus.rd_data, d[15]);
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    do_clr();
    bus.valid_fifo = 1; bus.done_fifo = 1; bus.people_thing_out = 8'h5A; step();
    bus.valid_fifo = 0; bus.done_fifo = 0; bus.rd_sel = 2'd0; bus.rd_addr = 4'd0; step();
    n_checks++;
    if ({bus.fifo_cnt, bus.rd_data, bus.err} !== {5'd1, 8'h5A, 1'b0})
      $display("FAIL valid_done: got cnt=%0d data=%h err=%0d expected cnt=1 data=5a err=0",
               bus.fifo_cnt, bus.rd_data, bus.err);
    else n_pass++;
    bus.valid_fifo = 1; step(); bus.valid_fifo = 0;
    n_checks++;
    if ({bus.fifo_cnt, bus.err} !== {5'd1, 1'b1})
      $display("FAIL valid_after_done: got cnt=%0d err=%0d expected cnt=1 err=1", bus.fifo_cnt, bus.err);
    else n_pass++;
    // shared-bus collision, then clear racing a valid
    do_clr();
    bus.valid_lifo = 1; bus.valid_fifo2 = 1; bus.thing_out = CH_SEMI; step();
    bus.valid_lifo = 0; bus.valid_fifo2 = 0;
    n_checks++;
    if ({bus.lifo_cnt, bus.fifo2_cnt, bus.err} !== {5'd1, 5'd1, 1'b1})
      $display("FAIL collision: got %0d/%0d err=%0d expected 1/1 err=1", bus.lifo_cnt, bus.fifo2_cnt, bus.err);
    else n_pass++;
    bus.clr = 1; bus.valid_fifo = 1; step(); idle_inputs();
    n_checks++;
    if ({bus.fifo_cnt, bus.lifo_cnt, bus.err} !== 11'd0)
      $display("FAIL clr_wins: got fifo=%0d lifo=%0d err=%0d expected all 0", bus.fifo_cnt, bus.lifo_cnt, bus.err);
    else n_pass++;
    bus.done_fifo2 = 1; step(); bus.done_fifo2 = 0; bus.valid_fifo2 = 1; step(); bus.valid_fifo2 = 0;
    n_checks++;
    if ({bus.fifo2_cnt, bus.err} !== {5'd0, 1'b1})
      $display("FAIL done_in_idle: got cnt=%0d err=%0d expected cnt=0 err=1", bus.fifo2_cnt, bus.err);
    else n_pass++;
  endtask

  task automatic test_completion();
    int order [3];
    int r;
    do_clr();
    r = int'($urandom_range(0, 5));
    order = '{r % 3, (r % 3 + 1 + r / 3) % 3, 0};
    order[2] = 3 - order[0] - order[1];
    for (int k = 0; k < 3; k++) begin
      bus.done_fifo = (order[k] == 0); bus.done_lifo = (order[k] == 1); bus.done_fifo2 = (order[k] == 2);
      step(); idle_inputs();
      n_checks++;
      if (bus.all_done !== (k == 2)) $display("FAIL all_done[%0d]: got %0d expected %0d", k, bus.all_done, k == 2);
      else n_pass++;
    end
    do_clr();
    n_checks++;
    if (dut_vec() !== 29'd0) $display("FAIL clr_all: got %h expected %h", dut_vec(), 29'd0);
    else n_pass++;
  endtask

  task automatic test_reset_midrun();
    do_clr();
    for (int i = 0; i < 5; i++) begin
      bus.valid_fifo = 1; bus.people_thing_out = 8'($urandom); step();
    end
    idle_inputs();
    @(negedge clk); #2 rst = 1; model_reset();
    #1;
    n_checks++;
    if (dut_vec() !== 29'd0) $display("FAIL async_reset: got %h expected %h", dut_vec(), 29'd0);
    else n_pass++;
    #1 rst = 0;
    bus.valid_fifo = 1; bus.people_thing_out = 8'h51; step();
    bus.valid_fifo = 0; bus.rd_sel = 2'd0; bus.rd_addr = 4'd0; step();
    n_checks++;
    if ({bus.fifo_cnt, bus.rd_data} !== {5'd1, 8'h51})
      $display("FAIL reset_restart: got cnt=%0d data=%h expected cnt=1 data=51", bus.fifo_cnt, bus.rd_data);
    else n_pass++;
  endtask

  task automatic test_random();
    do_clr();
    for (int i = 0; i < 800; i++) begin
      bus.valid_fifo  = ($urandom_range(0, 1) == 1);
      bus.valid_lifo  = ($urandom_range(0, 2) == 0);
      bus.valid_fifo2 = ($urandom_range(0, 2) == 0);
      bus.people_thing_out = 8'($urandom);
      bus.thing_out   = 8'($urandom);
      bus.done_thing  = ($urandom_range(0, 3) == 0);
      bus.done_fifo   = ($urandom_range(0, 39) == 0);
      bus.done_lifo   = ($urandom_range(0, 39) == 0);
      bus.done_fifo2  = ($urandom_range(0, 39) == 0);
      bus.clr         = ($urandom_range(0, 59) == 0);
      bus.rd_sel      = 2'($urandom);
      bus.rd_addr     = 4'($urandom);
      step();
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("FAIL random[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
      else n_pass++;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fifo_capture();
    test_lifo_groups();
    test_overflow();
    test_same_cycle();
    test_completion();
    test_reset_midrun();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
